// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared constants and types for the instruction-fetch slice
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : instruction-memory, decode and redirect signals of fetch
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Fetch-unit side
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

  // Memory / decode / branch-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : DEPTH-entry synchronous FIFO of {pc, instruction} with flush
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         push,
  input  fetch_entry_t      push_entry,
  input  wire logic         pop,
  input  wire logic         flush,
  output fetch_entry_t      head,
  output logic [CW-1:0]     count,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign pop_ok = pop && !empty;
  // An empty FIFO presents all-zero data and pc to decode
  assign head   = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC, request issue, response kill and decode hand-off.
//              Define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import riscv_pkg::*;
#(
  parameter  logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter  int              DEPTH    = 2,
  localparam int              CW       = $clog2(DEPTH + 1)
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_stall
`endif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   kill_q, kill_d;

  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            pop;
  logic            req_fire;
  logic            rsp_keep;
  logic [CW:0]     committed;
  logic            credit_ok;

  assign pop = !fifo_empty && bus.instr_ready;

  // Slots already promised; a pop this cycle frees one for immediate reuse,
  // which is what sustains one instruction per cycle at DEPTH=2.
  assign committed = {1'b0, outstanding_q} + {1'b0, fifo_count} - (CW+1)'(pop);
  assign credit_ok = committed < (CW+1)'(DEPTH);

  // rst_n gate keeps the request low throughout reset
  assign bus.imem_req_valid = rst_n && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = pc_q;

  assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep   = bus.imem_rsp_valid && (kill_q == '0) && !bus.redirect_valid;
  assign push_entry = '{pc: rsp_pc_q, data: bus.imem_rsp_data};

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = head.data;
  assign bus.instr_pc    = head.pc;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    if (bus.redirect_valid) begin
      pc_d          = align_pc(bus.redirect_pc);
      rsp_pc_d      = align_pc(bus.redirect_pc);
      outstanding_d = outstanding_q - CW'(bus.imem_rsp_valid);
      // outstanding already includes the requests marked by kill_q, so every
      // request still in flight after this cycle is now to be dropped.
      kill_d        = outstanding_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_STEP;
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (kill_q != '0)) begin
        kill_d = kill_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (rsp_keep),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // A pop in a redirect cycle is discarded by decode, so it is not counted
  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop && !bus.redirect_valid);
    perf_stall_d   = perf_stall_q + 32'(bus.instr_ready && fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : scoreboard bench for fetch_unit with a latency-k memory model
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int              DEPTH = 2;
  localparam logic [31:0]     RPC   = 32'h0000_0000;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   mem_k   = 1;

  mreq_t       mq[$];
  exp_t        exp_q[$];
  logic [31:0] model_pc = RPC;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  fetch_unit_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(
    .RESET_PC (RPC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Memory: in-order responses k cycles after acceptance, squashed by reset
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) mq.delete();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_pc   = RPC;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && !bus.redirect_valid) begin
          n_tests++;
          if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== prev_addr) begin
            n_fail++;
            $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h",
                     bus.imem_req_valid, bus.imem_req_addr, prev_addr);
          end
        end
        if (bus.redirect_valid) begin
          n_tests++;
          if (bus.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_in_redirect: valid=%b, required 0", bus.imem_req_valid);
          end
          exp_q.delete();
          model_pc = {bus.redirect_pc[31:2], 2'b00};
        end else begin
          if (bus.instr_valid && bus.instr_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL pop_unexpected: pc=%h instr=%h, required no instruction",
                       bus.instr_pc, bus.instr);
            end else begin
              e = exp_q.pop_front();
              if (bus.instr_pc !== e.pc || bus.instr !== e.data) begin
                n_fail++;
                $display("FAIL pop_data: pc=%h instr=%h, required pc=%h instr=%h",
                         bus.instr_pc, bus.instr, e.pc, e.data);
              end
            end
          end
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            n_tests++;
            if (bus.imem_req_addr !== model_pc) begin
              n_fail++;
              $display("FAIL req_addr: addr=%h, required %h", bus.imem_req_addr, model_pc);
            end
            exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
            mq.push_back('{addr: bus.imem_req_addr, due: cyc + mem_k});
            model_pc = model_pc + 32'd4;
          end
        end
        if (!bus.instr_valid) begin
          n_tests++;
          if (bus.instr !== '0 || bus.instr_pc !== '0) begin
            n_fail++;
            $display("FAIL idle_out: instr=%h pc=%h, required 0 0", bus.instr, bus.instr_pc);
          end
        end
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr  = bus.imem_req_addr;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    mem_k = 1;
    tick(3);
    n_tests++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: req=%b instr=%b, required 0 0", bus.imem_req_valid, bus.instr_valid);
    end
    n_tests++;
    if (bus.instr !== '0 || bus.instr_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h pc=%h, required 0 0", bus.instr, bus.instr_pc);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h, required 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
  endtask

  task automatic test_stream();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.instr_valid !== (c >= 3)) begin
        n_fail++;
        $display("FAIL stream_valid c%0d: valid=%b, required %b", c, bus.instr_valid, c >= 3);
      end
      if (c == 3) begin
        n_tests++;
        if (bus.instr_pc !== RPC) begin
          n_fail++;
          $display("FAIL stream_first_pc: pc=%h, required %h", bus.instr_pc, RPC);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    tick(1);
    bus.imem_req_ready = 1'b0;
    tick(6);
    bus.instr_ready    = 1'b0;
    bus.imem_req_ready = 1'b1;
    acc = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) acc++;
    end
    n_tests++;
    if (acc != DEPTH || bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure: accepted=%0d req=%b instr=%b, required %0d 0 1",
               acc, bus.imem_req_valid, bus.instr_valid, DEPTH);
    end
    tick(1);
    bus.instr_ready = 1'b1;
    tick(6);
  endtask

  task automatic test_req_stall();
    logic [31:0] a0;
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    a0 = bus.imem_req_addr;
    n_tests++;
    if (bus.imem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_valid: valid=%b, required 1", bus.imem_req_valid);
    end
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (bus.imem_req_addr !== a0) begin
        n_fail++;
        $display("FAIL stall_addr: addr=%h, required %h", bus.imem_req_addr, a0);
      end
    end
    tick(1);
    bus.imem_req_ready = 1'b1;
    tick(1);
    n_tests++;
    if (bus.imem_req_addr !== a0 + 32'd4) begin
      n_fail++;
      $display("FAIL stall_advance: addr=%h, required %h", bus.imem_req_addr, a0 + 32'd4);
    end
    tick(4);
  endtask

  task automatic test_redirect_inflight();
    bit ok;
    bus.imem_req_ready = 1'b0;
    tick(6);
    mem_k = 3;
    bus.imem_req_ready = 1'b1;
    tick(2);
    n_tests++;
    if (mq.size() != 2) begin
      n_fail++;
      $display("FAIL inflight_setup: in flight=%0d, required 2", mq.size());
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    tick(1);
    bus.redirect_valid = 1'b0;
    wait_valid(ok);
    n_tests++;
    if (!ok || bus.instr_pc !== 32'h0000_0100 || bus.instr !== mem_word(32'h0000_0100)) begin
      n_fail++;
      $display("FAIL redirect_first: seen=%0d pc=%h instr=%h, required pc=%h instr=%h",
               ok, bus.instr_pc, bus.instr, 32'h100, mem_word(32'h100));
    end
    mem_k = 1;
    tick(8);
  endtask

  task automatic test_redirect_collide();
    bit found;
    bit ok;
    mem_k = 2;
    tick(4);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #2;
      if (bus.imem_rsp_valid && bus.instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL collide_setup: no cycle with response and pop, required one");
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0181;
    tick(1);
    bus.redirect_pc    = 32'h0000_0202;
    tick(1);
    bus.redirect_valid = 1'b0;
    wait_valid(ok);
    n_tests++;
    if (!ok || bus.instr_pc !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL redirect_double: seen=%0d pc=%h, required pc=00000200", ok, bus.instr_pc);
    end
    mem_k = 1;
    tick(8);
  endtask

  task automatic test_wrap();
    bit ok;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick(1);
    bus.redirect_valid = 1'b0;
    wait_valid(ok);
    n_tests++;
    if (!ok || bus.instr_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_top: seen=%0d pc=%h, required fffffffc", ok, bus.instr_pc);
    end
    wait_valid(ok);
    n_tests++;
    if (!ok || bus.instr_pc !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL wrap_zero: seen=%0d pc=%h, required 00000000", ok, bus.instr_pc);
    end
    tick(4);
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_pc !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: req=%b instr=%b pc=%h, required 0 0 0",
               bus.imem_req_valid, bus.instr_valid, bus.instr_pc);
    end
    tick(2);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin
      n_fail++;
      $display("FAIL midreset_restart: valid=%b addr=%h, required 1 %h",
               bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
    tick(10);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
